// File: rtl/trajectory_scan_ctrl_if.sv
// Signal bundle between the planner, the two grid RAMs and trajectory_scan_ctrl.
// hit_count exists only when TRAJ_SCAN_FULL_EN is defined.
interface trajectory_scan_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] traj_rdata;
    logic [DATA_W-1:0] obst_rdata;
    logic [7:0]        deadline;
    logic              hit_valid;
    logic [ADDR_W-1:0] hit_addr;
`ifdef TRAJ_SCAN_FULL_EN
    logic [ADDR_W:0]   hit_count;

    modport master (
        input  start, abort, traj_rdata, obst_rdata,
        output busy, done, rd_en, rd_addr, deadline, hit_valid, hit_addr, hit_count
    );

    modport slave (
        output start, abort, traj_rdata, obst_rdata,
        input  busy, done, rd_en, rd_addr, deadline, hit_valid, hit_addr, hit_count
    );
`else
    modport master (
        input  start, abort, traj_rdata, obst_rdata,
        output busy, done, rd_en, rd_addr, deadline, hit_valid, hit_addr
    );

    modport slave (
        output start, abort, traj_rdata, obst_rdata,
        input  busy, done, rd_en, rd_addr, deadline, hit_valid, hit_addr
    );
`endif
endinterface

// File: rtl/trajectory_scan_ctrl.sv
// Walks the trajectory and obstacle grids together and turns the first collision into a deadline code.
// Define TRAJ_SCAN_FULL_EN to scan every word and count all colliding words (adds hit_count).
module trajectory_scan_ctrl #(
    parameter int DEPTH      = 2048,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int TIME_SHIFT = 3
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    trajectory_scan_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

`ifdef TRAJ_SCAN_FULL_EN
    localparam bit EARLY_EXIT = 1'b0;
`else
    localparam bit EARLY_EXIT = 1'b1;
`endif

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_rdAddr;
    logic              r_cmpValid;
    logic [ADDR_W-1:0] r_cmpAddr;
    logic [7:0]        r_deadline;
    logic              r_hitValid;
    logic [ADDR_W-1:0] r_hitAddr;

    logic [DATA_W-1:0] w_andWord;
    logic              w_hit;
    logic              w_lastIssue;
    logic              w_rdEn;
    logic              w_commit;
    logic              w_finHit;
    logic [ADDR_W-1:0] w_finAddr;
    logic [ADDR_W-1:0] w_t;
    logic [7:0]        w_deadline;

    assign w_andWord   = bus.traj_rdata & bus.obst_rdata;
    assign w_hit       = r_cmpValid && (w_andWord != '0);
    assign w_lastIssue = (r_state == SCAN) && (r_rdAddr == ADDR_W'(DEPTH - 1));

    // Abort outranks everything, including a hit seen in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_rdEn      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.abort)
                    w_nextState = SCAN;
            end
            SCAN: begin
                w_rdEn = !(EARLY_EXIT && w_hit);
                if (bus.abort) begin
                    w_nextState = IDLE;
                end else if (EARLY_EXIT && w_hit) begin
                    w_nextState = FIN;
                    w_commit    = 1'b1;
                end else if (w_lastIssue) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    w_nextState = IDLE;
                end else if (r_cmpValid) begin
                    w_nextState = FIN;
                    w_commit    = 1'b1;
                end
            end
            FIN: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

`ifdef TRAJ_SCAN_FULL_EN
    logic              r_anyHit;
    logic [ADDR_W-1:0] r_firstAddr;
    logic [ADDR_W:0]   r_hitCnt;
    logic [ADDR_W:0]   r_hitCount;

    assign w_finHit  = r_anyHit || w_hit;
    assign w_finAddr = r_anyHit ? r_firstAddr : r_cmpAddr;

    // Accumulates the first collision and the collision count over the whole scan.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_anyHit    <= 1'b0;
            r_firstAddr <= '0;
            r_hitCnt    <= '0;
            r_hitCount  <= '0;
        end else if (r_state == IDLE && w_nextState == SCAN) begin
            r_anyHit    <= 1'b0;
            r_firstAddr <= '0;
            r_hitCnt    <= '0;
            r_hitCount  <= '0;
        end else if (r_state == SCAN || r_state == DRAIN) begin
            if (w_hit) begin
                r_hitCnt <= r_hitCnt + 1'b1;
                if (!r_anyHit) begin
                    r_anyHit    <= 1'b1;
                    r_firstAddr <= r_cmpAddr;
                end
            end
            if (w_commit)
                r_hitCount <= r_hitCnt + {{ADDR_W{1'b0}}, w_hit};
        end
    end

    assign bus.hit_count = r_hitCount;
`else
    assign w_finHit  = w_hit;
    assign w_finAddr = r_cmpAddr;
`endif

    assign w_t = w_finAddr >> TIME_SHIFT;

    always_comb begin
        w_deadline = 8'd255;
        if (w_finHit) begin
            if (w_t == '0)
                w_deadline = 8'd0;
            else if (w_t > ADDR_W'(254))
                w_deadline = 8'd254;
            else
                w_deadline = 8'(w_t);
        end
    end

    // The read address and its compare flag travel one cycle apart so each compare knows its word index.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state    <= IDLE;
            r_rdAddr   <= '0;
            r_cmpValid <= 1'b0;
            r_cmpAddr  <= '0;
            r_deadline <= '0;
            r_hitValid <= 1'b0;
            r_hitAddr  <= '0;
        end else begin
            r_state    <= w_nextState;
            r_cmpValid <= w_rdEn && !bus.abort;
            r_cmpAddr  <= r_rdAddr;
            if (r_state == IDLE)
                r_rdAddr <= '0;
            else if (r_state == SCAN)
                r_rdAddr <= r_rdAddr + 1'b1;
            if (w_commit) begin
                r_deadline <= w_deadline;
                r_hitValid <= w_finHit;
                if (w_finHit)
                    r_hitAddr <= w_finAddr;
            end
        end
    end

    assign bus.busy      = (r_state == SCAN) || (r_state == DRAIN);
    assign bus.done      = (r_state == FIN);
    assign bus.rd_en     = w_rdEn;
    assign bus.rd_addr   = r_rdAddr;
    assign bus.deadline  = r_deadline;
    assign bus.hit_valid = r_hitValid;
    assign bus.hit_addr  = r_hitAddr;

endmodule

// File: tb/tb_trajectory_scan_ctrl.sv
// Directed and randomized bench for trajectory_scan_ctrl with a grid-RAM model and a whole-grid reference model.
// Builds with or without TRAJ_SCAN_FULL_EN.
module tb_trajectory_scan_ctrl;

    localparam int DEPTH      = 2048;
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 32;
    localparam int TIME_SHIFT = 3;

    logic CLK   = 1'b0;
    logic RST_n = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    logic [DATA_W-1:0] trajMem [DEPTH];
    logic [DATA_W-1:0] obstMem [DEPTH];

    trajectory_scan_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    trajectory_scan_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIME_SHIFT(TIME_SHIFT)
    ) dut (
        .CLK(CLK),
        .RST_n(RST_n),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous-read grid RAMs; unread cycles return noise so stale data cannot fake a compare.
    always @(posedge CLK) begin
        if (bus.rd_en) begin
            bus.traj_rdata <= trajMem[bus.rd_addr];
            bus.obst_rdata <= obstMem[bus.rd_addr];
        end else begin
            bus.traj_rdata <= $urandom;
            bus.obst_rdata <= $urandom;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < DEPTH; i++) begin
            trajMem[i] = '0;
            obstMem[i] = '0;
        end
    endtask

    task automatic fillRandom(input int nHits);
        int p;
        int b;
        for (int i = 0; i < DEPTH; i++) begin
            trajMem[i] = $urandom;
            obstMem[i] = $urandom & ~trajMem[i];
        end
        for (int h = 0; h < nHits; h++) begin
            p = $urandom_range(DEPTH - 1, 0);
            b = $urandom_range(DATA_W - 1, 0);
            trajMem[p][b] = 1'b1;
            obstMem[p][b] = 1'b1;
        end
    endtask

    // Reference: search the whole grid pair for overlapping bits.
    task automatic modelScan(output int firstA, output int nHits);
        firstA = -1;
        nHits  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((trajMem[i] & obstMem[i]) != 0) begin
                nHits++;
                if (firstA < 0) firstA = i;
            end
        end
    endtask

    function automatic int modelDeadline(input int firstA);
        int t;
        if (firstA < 0) return 255;
        t = firstA / (1 << TIME_SHIFT);
        if (t == 0) return 0;
        if (t > 254) return 254;
        return t;
    endfunction

    task automatic applyStimulus(input string tag, input int busyStartAt);
        int firstA, nHits, expLat, expLast, c0, rel, doneCyc, lastRd, addrErr, changed;
        logic [7:0] prevDl;
        logic prevHv;
        modelScan(firstA, nHits);
`ifdef TRAJ_SCAN_FULL_EN
        expLat  = DEPTH + 2;
        expLast = DEPTH;
`else
        expLat  = (firstA < 0) ? DEPTH + 2 : firstA + 3;
        expLast = (firstA < 0) ? DEPTH : firstA + 1;
`endif
        prevDl  = bus.deadline;
        prevHv  = bus.hit_valid;
        doneCyc = -1;
        lastRd  = 0;
        addrErr = 0;
        changed = 0;
        @(negedge CLK);
        c0 = cyc;
        for (int k = 0; k < DEPTH + 20; k++) begin
            rel = cyc - c0;
            bus.start = (rel == 0) || (busyStartAt > 0 && rel == busyStartAt);
            if (bus.rd_en) begin
                if (bus.rd_addr !== ADDR_W'(rel - 1)) addrErr++;
                lastRd = rel;
            end
            if (bus.done) begin
                doneCyc = rel;
                break;
            end
            if (bus.deadline !== prevDl || bus.hit_valid !== prevHv) changed = 1;
            @(negedge CLK);
        end
        bus.start = 1'b0;
        checkOutput({tag, "_done_cycle"}, doneCyc, expLat);
        checkOutput({tag, "_addr_seq_errs"}, addrErr, 0);
        checkOutput({tag, "_last_rd_cycle"}, lastRd, expLast);
        checkOutput({tag, "_held_until_fin"}, changed, 0);
        checkOutput({tag, "_deadline"}, bus.deadline, modelDeadline(firstA));
        checkOutput({tag, "_hit_valid"}, bus.hit_valid, (firstA >= 0) ? 1 : 0);
        if (firstA >= 0) checkOutput({tag, "_hit_addr"}, bus.hit_addr, firstA);
`ifdef TRAJ_SCAN_FULL_EN
        checkOutput({tag, "_hit_count"}, bus.hit_count, nHits);
`endif
        @(negedge CLK);
        checkOutput({tag, "_idle_after_fin"}, {bus.busy, bus.done}, 0);
    endtask

    task automatic applyAbort(input int abortAt);
        logic [7:0] prevDl;
        logic prevHv;
        int c0, sawDone;
        prevDl = bus.deadline;
        prevHv = bus.hit_valid;
        @(negedge CLK);
        c0 = cyc;
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (abortAt - 1) @(negedge CLK);
        checkOutput("abort_busy_before", bus.busy, 1);
        bus.abort = 1'b1;
        @(negedge CLK);
        bus.abort = 1'b0;
        checkOutput("abort_cycle", cyc - c0, abortAt + 1);
        checkOutput("abort_busy_after", bus.busy, 0);
        checkOutput("abort_rd_en_after", bus.rd_en, 0);
        sawDone = 0;
        repeat (DEPTH + 10) begin
            if (bus.done) sawDone = 1;
            @(negedge CLK);
        end
        checkOutput("abort_no_done", sawDone, 0);
        checkOutput("abort_deadline_held", bus.deadline, prevDl);
        checkOutput("abort_hit_valid_held", bus.hit_valid, prevHv);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, bus.busy, 0);
        checkOutput({tag, "_done"}, bus.done, 0);
        checkOutput({tag, "_rd_en"}, bus.rd_en, 0);
        checkOutput({tag, "_rd_addr"}, bus.rd_addr, 0);
        checkOutput({tag, "_deadline"}, bus.deadline, 0);
        checkOutput({tag, "_hit_valid"}, bus.hit_valid, 0);
        checkOutput({tag, "_hit_addr"}, bus.hit_addr, 0);
`ifdef TRAJ_SCAN_FULL_EN
        checkOutput({tag, "_hit_count"}, bus.hit_count, 0);
`endif
    endtask

    initial begin
        int sawDone;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        clearMem();

        #2 RST_n = 1'b0;
        #1 checkResetValues("reset");
        repeat (3) @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);

        applyStimulus("all_zero", 0);

        trajMem[100] = 32'h1;
        obstMem[100] = 32'h1;
        applyStimulus("hit100", 0);

        clearMem();
        trajMem[5] = 32'h8000_0000;
        obstMem[5] = 32'hC000_0000;
        applyStimulus("hit5", 0);

        clearMem();
        trajMem[DEPTH-1] = 32'h0000_0100;
        obstMem[DEPTH-1] = 32'h0000_0100;
        applyStimulus("hit_last", 0);

        for (int i = 0; i < DEPTH; i++) begin
            trajMem[i] = 32'hF0;
            obstMem[i] = 32'h0F;
        end
        applyStimulus("disjoint", 0);
        obstMem[40] = 32'h1F;
        applyStimulus("hit40_busy_start", 20);

        obstMem[40] = 32'h0F;
        applyAbort(500);

        @(negedge CLK);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        sawDone = 0;
        repeat (5) begin
            if (bus.busy || bus.rd_en || bus.done) sawDone = 1;
            @(negedge CLK);
        end
        checkOutput("start_abort_no_scan", sawDone, 0);

        for (int r = 0; r < 4; r++) begin
            fillRandom(r);
            applyStimulus($sformatf("random%0d", r), (r == 2) ? 7 : 0);
        end

        clearMem();
        trajMem[10] = 32'h2; obstMem[10] = 32'h2;
        trajMem[20] = 32'h4; obstMem[20] = 32'h6;
        trajMem[30] = 32'h8; obstMem[30] = 32'hF;
        applyStimulus("three_hits", 0);

        clearMem();
        @(negedge CLK);
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (300) @(negedge CLK);
        checkOutput("midscan_busy", bus.busy, 1);
        #2 RST_n = 1'b0;
        #1 checkResetValues("midscan_reset");
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);

        trajMem[10] = 32'h2; obstMem[10] = 32'h2;
        trajMem[20] = 32'h4; obstMem[20] = 32'h6;
        trajMem[30] = 32'h8; obstMem[30] = 32'hF;
        applyStimulus("after_reset", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trajectory_scan_ctrl.md
Name: trajectory_scan_ctrl

Overview:
- Sequences the collision check between the trajectory occupancy grid and the obstacle occupancy grid.
- On a start request it walks both grid RAMs word by word, in trajectory-time order, over a shared read address. Each word pair is ANDed to find the first colliding word.
- It then converts the collision position into the 8-bit deadline code consumed by the planner: 0 = fail, 1..254 = maximum time / re-plan, 255 = success.
- Sits between the top-level planner state machine and the two grid memories.

Parameters:
- DEPTH, 2048, number of grid words scanned per run (power of two).
- ADDR_W, 11, grid address width; log2(DEPTH).
- DATA_W, 32, grid word width.
- TIME_SHIFT, 3, right-shift converting a word index into a deadline time unit.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle scan request; sampled only in IDLE.
- abort  input  1  cancel the scan in progress.
- busy  output  1  high while in SCAN or DRAIN.
- done  output  1  one-cycle pulse when deadline/hit outputs are updated.
- rd_en  output  1  read enable to both grid RAMs.
- rd_addr  output  ADDR_W  shared read address to both grid RAMs.
- traj_rdata  input  DATA_W  trajectory grid data; valid 1 cycle after rd_en.
- obst_rdata  input  DATA_W  obstacle grid data; valid 1 cycle after rd_en.
- deadline  output  8  result code.
- hit_valid  output  1  last completed scan found a collision.
- hit_addr  output  ADDR_W  first colliding word index of the last completed scan.

Behaviour:
- Reset (asynchronous, RST_n low): state IDLE; busy=0, done=0, rd_en=0, rd_addr=0, deadline=0, hit_valid=0, hit_addr=0; read pipeline valid flag cleared.
- States: IDLE, SCAN, DRAIN, FIN.
- IDLE -> SCAN on start=1 with abort=0. Call the start cycle cycle 0.
- SCAN:
  - rd_en=1; rd_addr runs 0..DEPTH-1, one address per cycle starting in cycle 1.
  - After issuing DEPTH-1, go to DRAIN.
- Compare stage:
  - One cycle after each read, a registered valid flag qualifies (traj_rdata & obst_rdata) != 0.
  - The address of that read is delayed one cycle alongside the flag.
- Hit:
  - On the first nonzero compare, latch hit_addr = A; rd_en drops in the following cycle; go to FIN.
  - Any read already in flight is discarded.
- DRAIN: rd_en=0; wait for the last compare, then go to FIN.
- FIN:
  - done=1 for exactly one cycle; deadline and hit_valid update on the same edge; then IDLE.
  - busy=0 in FIN.
- Latency: no hit -> done in cycle DEPTH+2; first hit at A -> done in cycle A+3.
- Deadline arithmetic, using t = A >> TIME_SHIFT (ADDR_W bits):
  - no hit: 255;
  - hit with t==0: 0 (fail);
  - otherwise: min(t, 254).
  - The compare against 254 is unsigned at ADDR_W width. It never yields 255 on a hit.
- Between scans, deadline, hit_valid and hit_addr hold their values until the next FIN.
- start while busy: ignored; no queueing.
- abort in SCAN or DRAIN:
  - Next state IDLE, rd_en=0 next cycle, no done pulse.
  - Results unchanged; in-flight compare discarded.
- abort and start in the same IDLE cycle: abort wins, so there is no scan.
- abort in FIN: ignored; the result commits.
- Hit on the last word (A=DEPTH-1) behaves as a normal hit. With the default parameters, deadline = min(2047>>3, 254) = 254.
- Reset asserted mid-scan: immediate return to the reset values above.

Optional Feature:
- Macro: TRAJ_SCAN_FULL_EN.
- Defined:
  - No early exit; all DEPTH words are always scanned, and done always arrives in cycle DEPTH+2.
  - hit_addr holds the FIRST collision.
  - Adds output hit_count [ADDR_W:0]: number of colliding words. It is reset to 0, cleared at scan start, and updated at FIN.
- Undefined:
  - Early-exit behaviour as above.
  - hit_count port absent.

Test Plan:
- Both grids all-zero, start pulse -> addresses 0..2047 issued in cycles 1..2048; done in cycle 2050; deadline=255, hit_valid=0.
- Collision at word 100 only (traj=0x1, obst=0x1) -> done in cycle 103; hit_addr=100, deadline=12; rd_en low from cycle 102.
- Collision at word 5 -> deadline=0, hit_valid=1. Collision at word 2047 -> deadline=254.
- traj=0xF0 and obst=0x0F in every word (overlapping grids, disjoint bits) -> no hit, deadline=255. Repeat the scan with a hit at 40 -> deadline=5, and the earlier result is overwritten only at FIN.
- abort in cycle 500 of a scan -> IDLE in cycle 501, no done, previous deadline held. start with abort in IDLE -> no scan. start while busy -> ignored.
- With TRAJ_SCAN_FULL_EN, collisions at words 10, 20, 30 -> done in cycle 2050; hit_addr=10, hit_count=3, deadline=1. Also assert RST_n low mid-scan -> all outputs at reset values immediately.
